maze_tile_plotter: RTL and testbench

//  Downstream of the maze position counter. Turns its (tile address, pixel x/y) stream into VGA

---
 rtl/maze_tile_plotter.sv | 152 +++++++++++++++
 tb/tb_maze_tile_plotter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_tile_plotter.sv
// Purpose: maps the maze counter's pixel stream to VGA writes via tile RAM lookup; optional MAZE_PLAYER_OVERLAY_EN.
// Latency: pix_valid sampled at edge N -> plot high after edge N+2; one pixel per cycle.
// Backpressure: none; upstream is throttled only through pos_enable (RUN state).
module maze_tile_plotter #(
   parameter int                  COLOUR_W      = 3,
   parameter logic [COLOUR_W-1:0] PATH_COLOUR   = 3'b111,
   parameter logic [COLOUR_W-1:0] WALL_COLOUR   = 3'b000,
   parameter logic [COLOUR_W-1:0] START_COLOUR  = 3'b010,
   parameter logic [COLOUR_W-1:0] EXIT_COLOUR   = 3'b100,
   parameter logic [COLOUR_W-1:0] PLAYER_COLOUR = 3'b001
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                pix_valid,
   input  logic [9:0]          tile_addr,
   input  logic [8:0]          pix_x,
   input  logic [8:0]          pix_y,
   input  logic                frame_done_in,
   output logic                pos_enable,
   output logic [9:0]          ram_addr,
   input  logic [2:0]          ram_q,
`ifdef MAZE_PLAYER_OVERLAY_EN
   input  logic [4:0]          player_x,
   input  logic [4:0]          player_y,
`endif
   output logic [8:0]          vga_x,
   output logic [7:0]          vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                plot,
   output logic                busy,
   output logic                done,
   output logic [15:0]         pix_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // Per-pixel sideband carried alongside the RAM read.
   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
`ifdef MAZE_PLAYER_OVERLAY_EN
      logic       ovl;
`endif
   } pix_t;

   state_t state, state_nxt;
   logic   drain_cnt;
   logic   capture;
   logic   v0, v1;
   pix_t   s0, s1;

   // Only 240 lines are ever drawn, so the top y bit never reaches the adapter.
   logic   unused_pix_y8;
   assign unused_pix_y8 = pix_y[8];

   assign capture = (state == RUN) && pix_valid;

   function automatic logic [COLOUR_W-1:0] tile_colour(input logic [2:0] code);
      case (code)
         3'd0:    tile_colour = PATH_COLOUR;
         3'd2:    tile_colour = START_COLOUR;
         3'd3:    tile_colour = EXIT_COLOUR;
         default: tile_colour = WALL_COLOUR;
      endcase
   endfunction

   // State register; drain_cnt marks the second DRAIN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= (state == DRAIN);
      end
   end

   // Next-state and control outputs. DRAIN lasts two cycles, the pipeline depth,
   // so a pixel captured alongside frame_done_in is plotted in the DONE cycle.
   always_comb begin
      state_nxt  = state;
      pos_enable = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            pos_enable = 1'b1;
            busy       = 1'b1;
            if (frame_done_in) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_cnt) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage 0 issues the RAM read; the wait stage holds sideband until ram_q arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         v0       <= 1'b0;
         v1       <= 1'b0;
         s0       <= '0;
         s1       <= '0;
         ram_addr <= '0;
      end else begin
         v0 <= capture;
         v1 <= v0;
         s1 <= s0;
         if (capture) begin
            ram_addr <= tile_addr;
            s0.x     <= pix_x;
            s0.y     <= pix_y[7:0];
`ifdef MAZE_PLAYER_OVERLAY_EN
            s0.ovl   <= (tile_addr[4:0] == player_x) && (tile_addr[9:5] == player_y);
`endif
         end
      end
   end

   // Stage 1: colour lookup, VGA write strobe and saturating pixel counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         plot       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         pix_count  <= '0;
      end else begin
         plot <= v1;
         if (v1) begin
            vga_x <= s1.x;
            vga_y <= s1.y;
`ifdef MAZE_PLAYER_OVERLAY_EN
            vga_colour <= s1.ovl ? PLAYER_COLOUR : tile_colour(ram_q);
`else
            vga_colour <= tile_colour(ram_q);
`endif
            if (pix_count != 16'hFFFF) pix_count <= pix_count + 16'd1;
         end
         if (state == IDLE && start) pix_count <= '0;
      end
   end

endmodule

// File: tb/tb_maze_tile_plotter.sv
module tb_maze_tile_plotter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       pix_valid = 1'b0;
   logic       frame_done_in = 1'b0;
   logic [9:0] tile_addr = '0;
   logic [8:0] pix_x = '0;
   logic [8:0] pix_y = '0;
   logic [2:0] ram_q = '0;
`ifdef MAZE_PLAYER_OVERLAY_EN
   logic [4:0] player_x = '0;
   logic [4:0] player_y = '0;
`endif
   logic        pos_enable;
   logic [9:0]  ram_addr;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        plot, busy, done;
   logic [15:0] pix_count;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } exp_t;

   exp_t       expq[$];
   logic [2:0] mem [0:1023];
   int         n_vec = 0;
   int         n_err = 0;

   maze_tile_plotter dut (
      .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
      .tile_addr(tile_addr), .pix_x(pix_x), .pix_y(pix_y),
      .frame_done_in(frame_done_in), .pos_enable(pos_enable),
      .ram_addr(ram_addr), .ram_q(ram_q),
`ifdef MAZE_PLAYER_OVERLAY_EN
      .player_x(player_x), .player_y(player_y),
`endif
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot),
      .busy(busy), .done(done), .pix_count(pix_count)
   );

   always #5 clk = ~clk;

   // Synchronous tile RAM model: data one cycle after the address.
   always @(posedge clk) ram_q <= mem[ram_addr];

   function automatic logic [2:0] exp_col(input logic [2:0] code);
      case (code)
         3'd0:    exp_col = 3'b111;
         3'd2:    exp_col = 3'b010;
         3'd3:    exp_col = 3'b100;
         default: exp_col = 3'b000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pix(input logic [9:0] a, input logic [8:0] x, input logic [8:0] y,
                           input logic [2:0] col, input bit push);
      tile_addr = a;
      pix_x     = x;
      pix_y     = y;
      pix_valid = 1'b1;
      if (push) expq.push_back({x, y[7:0], col});
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called just after the edge that sampled frame_done_in; done must be up in the third cycle.
   task automatic wait_done_from_edge(input string name);
      int cyc;
      cyc = 1;
      while (!done && cyc < 12) begin
         tick();
         cyc++;
      end
      check({name, "_done_latency"}, cyc, 3);
      check({name, "_done_high"}, done, 1);
   endtask

   task automatic after_done(input string name);
      tick();
      check({name, "_done_one_cycle"}, done, 0);
      check({name, "_idle_busy"}, busy, 0);
      check({name, "_idle_pos_enable"}, pos_enable, 0);
   endtask

   task automatic end_frame(input string name);
      frame_done_in = 1'b1;
      tick();
      frame_done_in = 1'b0;
      wait_done_from_edge(name);
      after_done(name);
   endtask

   // Scoreboard monitor: every plot strobe must match the oldest expected write.
   always @(negedge clk) begin
      exp_t e;
      if (plot) begin
         if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_plot: got plot at x=%0d y=%0d colour=%b, expected no plot",
                     vga_x, vga_y, vga_colour);
         end else begin
            e = expq.pop_front();
            check("plot_x", vga_x, e.x);
            check("plot_y", vga_y, e.y);
            check("plot_colour", vga_colour, e.c);
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 3'(i ^ (i >> 3));
      mem[33]  = 3'd1;
      mem[100] = 3'd0;
      mem[101] = 3'd2;
      mem[102] = 3'd3;
      mem[103] = 3'd5;
      mem[67]  = 3'd2;
      mem[68]  = 3'd0;

      // Reset state
      tick();
      tick();
      reset = 1'b0;
      check("rst_plot", plot, 0);
      check("rst_pos_enable", pos_enable, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pix_count", pix_count, 0);
      check("rst_vga_x", vga_x, 0);
      check("rst_vga_colour", vga_colour, 0);
      check("rst_ram_addr", ram_addr, 0);

      // Single pixel: wall tile, two-cycle latency
      start_frame();
      check("run_busy", busy, 1);
      check("run_pos_enable", pos_enable, 1);
      send_pix(10'd33, 9'd90, 9'd10, 3'b000, 1'b1);
      check("lat_plot_n", plot, 0);
      check("lat_ram_addr", ram_addr, 33);
      tick();
      check("lat_plot_n1", plot, 0);
      tick();
      check("lat_plot_n2", plot, 1);
      check("lat_vga_x", vga_x, 90);
      check("lat_vga_y", vga_y, 10);
      check("lat_colour", vga_colour, 3'b000);
      check("lat_pix_count", pix_count, 1);

      // Back-to-back codes 0,2,3,5
      send_pix(10'd100, 9'd10, 9'd20, 3'b111, 1'b1);
      send_pix(10'd101, 9'd11, 9'd20, 3'b010, 1'b1);
      send_pix(10'd102, 9'd12, 9'd20, 3'b100, 1'b1);
      send_pix(10'd103, 9'd13, 9'd20, 3'b000, 1'b1);
      tick();
      tick();
      check("burst_pix_count", pix_count, 5);

      // start during RUN is ignored
      start_frame();
      check("start_in_run_count", pix_count, 5);
      check("start_in_run_busy", busy, 1);
      end_frame("frame_a");
      check("frame_a_count", pix_count, 5);

      // pix_valid while IDLE is ignored
      for (int i = 0; i < 3; i++) send_pix(10'(i), 9'(i), 9'(i), 3'b000, 1'b0);
      tick();
      tick();
      check("idle_pix_plot", plot, 0);
      check("idle_pix_count", pix_count, 5);

      // Full 24x24 frame of 9x9 tiles; last pixel arrives with frame_done_in
      start_frame();
      check("frame_b_cleared", pix_count, 0);
      for (int ty = 0; ty < 24; ty++)
         for (int tx = 0; tx < 24; tx++)
            for (int py = 0; py < 9; py++)
               for (int px = 0; px < 9; px++) begin
                  logic [9:0] a;
                  a = {5'(ty), 5'(tx)};
                  if (ty == 23 && tx == 23 && py == 8 && px == 8) frame_done_in = 1'b1;
                  send_pix(a, 9'(tx * 9 + px), 9'(ty * 9 + py), exp_col(mem[a]), 1'b1);
               end
      frame_done_in = 1'b0;
      wait_done_from_edge("frame_b");
      check("frame_b_pix_count", pix_count, 46656);
      after_done("frame_b");
      check("frame_b_count_hold", pix_count, 46656);

`ifdef MAZE_PLAYER_OVERLAY_EN
      // Player overlay on tile (3,2) only
      player_x = 5'd3;
      player_y = 5'd2;
      start_frame();
      send_pix(10'd67, 9'd27, 9'd18, 3'b001, 1'b1);
      send_pix(10'd68, 9'd36, 9'd18, 3'b111, 1'b1);
      send_pix(10'd35, 9'd27, 9'd9, exp_col(mem[35]), 1'b1);
      end_frame("overlay");
      check("overlay_count", pix_count, 3);
`endif

      // Reset mid-RUN aborts an in-flight pixel
      start_frame();
      send_pix(10'd200, 9'd100, 9'd50, exp_col(mem[200]), 1'b1);
      tick();
      tick();
      send_pix(10'd201, 9'd101, 9'd50, 3'b000, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("midrst_plot", plot, 0);
      check("midrst_pos_enable", pos_enable, 0);
      check("midrst_busy", busy, 0);
      check("midrst_pix_count", pix_count, 0);
      for (int i = 0; i < 4; i++) tick();

      check("queue_empty", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
